regfile_bypass_scoreboard: RTL and testbench

- Parametrised general-purpose register file for the RISC-V pipeline.
- Two combinational read ports, one synchronous write port, register 0 hardwired to zero.
- Optional write-to-read bypass (writeback forwarding into decode).
- Per-register pending-write scoreboard that flags read operands whose producer has issued but not yet written back. The hazard unit uses these flags to generate stalls.

---
 rtl/regfile_bypass_scoreboard.sv | 132 +++++++++++++
 tb/tb_regfile_bypass_scoreboard.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass_scoreboard.sv
// RISC-V general-purpose register file: two combinational read ports, one write port,
// x0 hardwired to zero, optional writeback-to-decode bypass and a pending-write scoreboard.
module regfile_bypass_scoreboard #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [XLEN-1:0]   read_data1,
    output logic [XLEN-1:0]   read_data2,
    input  logic              write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [XLEN-1:0]   write_data,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    logic [XLEN-1:0] r_regs [1:NREG-1];
    logic [NREG-1:0] r_pending;
    logic [ADDR_W:0] r_pending_cnt;

    logic [NREG-1:0] w_wr_hit;
    logic [NREG-1:0] w_iss_hit;
    logic [NREG-1:0] w_pending_nxt;
    logic            w_byp1;
    logic            w_byp2;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] vec);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + (ADDR_W + 1)'(vec[i]);
        end
        return cnt;
    endfunction

    // Per-register write/issue decode; enables gate the compare so an unknown
    // address with its enable low cannot reach any register.
    always_comb begin
        w_wr_hit  = '0;
        w_iss_hit = '0;
        for (int r = 1; r < NREG; r++) begin
            w_wr_hit[r]  = write & (write_reg == ADDR_W'(r));
            w_iss_hit[r] = issue & (issue_reg == ADDR_W'(r));
        end
    end

    // Next scoreboard state: a new producer wins over a retiring one.
    always_comb begin
        w_pending_nxt = '0;
        for (int r = 1; r < NREG; r++) begin
            if (w_iss_hit[r]) begin
                w_pending_nxt[r] = 1'b1;
            end else if (w_wr_hit[r]) begin
                w_pending_nxt[r] = 1'b0;
            end else begin
                w_pending_nxt[r] = r_pending[r];
            end
        end
    end

    // Register storage for x1..xN-1; x0 has no flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w_wr_hit[r]) begin
                    r_regs[r] <= write_data;
                end
            end
        end
    end

    // Scoreboard bits and their registered population count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending     <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_pending     <= w_pending_nxt;
            r_pending_cnt <= popcount(w_pending_nxt);
        end
    end

    assign w_byp1 = BYPASS & write & (write_reg == read_reg1);
    assign w_byp2 = BYPASS & write & (write_reg == read_reg2);

    // Read port 1 data selection.
    always_comb begin
        w_rd1 = '0;
        if (read_reg1 == '0) begin
            w_rd1 = '0;
        end else if (w_byp1) begin
            w_rd1 = write_data;
        end else begin
            w_rd1 = r_regs[read_reg1];
        end
    end

    // Read port 2 data selection.
    always_comb begin
        w_rd2 = '0;
        if (read_reg2 == '0) begin
            w_rd2 = '0;
        end else if (w_byp2) begin
            w_rd2 = write_data;
        end else begin
            w_rd2 = r_regs[read_reg2];
        end
    end

    assign read_data1  = w_rd1;
    assign read_data2  = w_rd2;
    // r_pending[0] is never set, so x0 is never busy.
    assign busy1       = r_pending[read_reg1] & ~w_byp1;
    assign busy2       = r_pending[read_reg2] & ~w_byp2;
    assign pending_cnt = r_pending_cnt;

endmodule

// File: tb/tb_regfile_bypass_scoreboard.sv
// Directed bench for regfile_bypass_scoreboard; one bypassing and one non-bypassing
// instance share all inputs so both forwarding behaviours are checked side by side.
module tb_regfile_bypass_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  rr1, rr2, wreg, ireg;
    logic        wr, iss;
    logic [31:0] wdata;

    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_busy1, b_busy2, n_busy1, n_busy2;
    logic [5:0]  b_cnt, n_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_bypass_scoreboard #(.XLEN(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .read_reg1(rr1), .read_reg2(rr2),
        .read_data1(b_rd1), .read_data2(b_rd2),
        .write(wr), .write_reg(wreg), .write_data(wdata),
        .issue(iss), .issue_reg(ireg),
        .busy1(b_busy1), .busy2(b_busy2), .pending_cnt(b_cnt)
    );

    regfile_bypass_scoreboard #(.XLEN(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst),
        .read_reg1(rr1), .read_reg2(rr2),
        .read_data1(n_rd1), .read_data2(n_rd2),
        .write(wr), .write_reg(wreg), .write_data(wdata),
        .issue(iss), .issue_reg(ireg),
        .busy1(n_busy1), .busy2(n_busy2), .pending_cnt(n_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr  = 1'b0;
        iss = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rr1 = 5'd0; rr2 = 5'd0; wr = 1'b0; wreg = 5'd0; wdata = 32'd0;
        iss = 1'b0; ireg = 5'd0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_cnt", 32'(b_cnt), 32'd0);
        check("reset_busy1", 32'(b_busy1), 32'd0);

        // x0 write is discarded and never forwarded
        wr = 1'b1; wreg = 5'd0; wdata = 32'hDEADBEEF; rr1 = 5'd0; rr2 = 5'd0;
        #1;
        check("x0_byp_rd1", b_rd1, 32'd0);
        check("x0_byp_rd2", b_rd2, 32'd0);
        step();
        idle();
        #1;
        check("x0_rd1", b_rd1, 32'd0);
        check("x0_rd2", b_rd2, 32'd0);
        check("x0_busy2", 32'(b_busy2), 32'd0);
        check("x0_cnt", 32'(b_cnt), 32'd0);

        // reset clears stored data
        wr = 1'b1; wreg = 5'd5; wdata = 32'h12345678;
        step();
        idle(); rr1 = 5'd5;
        #1;
        check("x5_written", b_rd1, 32'h12345678);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("x5_after_rst", b_rd1, 32'd0);
        check("cnt_after_rst", 32'(b_cnt), 32'd0);

        // bypass versus no bypass
        wr = 1'b1; wreg = 5'd7; wdata = 32'hA5A5A5A5; rr1 = 5'd7;
        #1;
        check("byp_same_cycle", b_rd1, 32'hA5A5A5A5);
        check("nobyp_same_cycle", n_rd1, 32'd0);
        step();
        idle();
        #1;
        check("nobyp_next_cycle", n_rd1, 32'hA5A5A5A5);

        // scoreboard set, hold, clear
        iss = 1'b1; ireg = 5'd3; rr2 = 5'd3;
        #1;
        check("busy2_before_issue", 32'(b_busy2), 32'd0);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("busy2_hold", 32'(b_busy2), 32'd1);
            check("cnt_hold", 32'(b_cnt), 32'd1);
            step();
        end
        wr = 1'b1; wreg = 5'd3; wdata = 32'h55;
        #1;
        check("wb_busy2_byp", 32'(b_busy2), 32'd0);
        check("wb_rd2_byp", b_rd2, 32'h55);
        check("wb_busy2_nobyp", 32'(n_busy2), 32'd1);
        check("wb_rd2_nobyp", n_rd2, 32'd0);
        step();
        idle();
        #1;
        check("wb_cnt_cleared", 32'(b_cnt), 32'd0);
        check("wb_cnt_cleared_nb", 32'(n_cnt), 32'd0);
        check("wb_rd2_stored", n_rd2, 32'h55);

        // simultaneous issue and writeback to x9
        iss = 1'b1; ireg = 5'd9;
        step();
        wr = 1'b1; wreg = 5'd9; wdata = 32'd1;
        step();
        idle(); rr1 = 5'd9;
        #1;
        check("x9_still_busy", 32'(b_busy1), 32'd1);
        check("x9_cnt", 32'(b_cnt), 32'd1);
        check("x9_value", b_rd1, 32'd1);
        wr = 1'b1; wreg = 5'd9; wdata = 32'd2;
        step();
        idle();
        #1;
        check("x9_retired_cnt", 32'(b_cnt), 32'd0);

        // writeback to a non-pending register leaves count untouched
        wr = 1'b1; wreg = 5'd20; wdata = 32'h2020; rr1 = 5'd20;
        step();
        idle();
        #1;
        check("np_wb_data", b_rd1, 32'h2020);
        check("np_wb_cnt", 32'(b_cnt), 32'd0);
        check("np_wb_busy", 32'(b_busy1), 32'd0);

        // fill the scoreboard
        for (int r = 1; r < 32; r++) begin
            iss = 1'b1; ireg = 5'(r);
            step();
        end
        idle();
        #1;
        check("cnt_full", 32'(b_cnt), 32'd31);
        iss = 1'b1; ireg = 5'd0; rr1 = 5'd0;
        step();
        idle();
        #1;
        check("issue_x0_cnt", 32'(b_cnt), 32'd31);
        check("issue_x0_busy1", 32'(b_busy1), 32'd0);

        // reset wins over write and issue
        rst = 1'b1; wr = 1'b1; wreg = 5'd4; wdata = 32'h44; iss = 1'b1; ireg = 5'd4;
        step();
        rst = 1'b0; idle(); rr1 = 5'd4;
        #1;
        check("rst_prio_data", b_rd1, 32'd0);
        check("rst_prio_cnt", 32'(b_cnt), 32'd0);
        check("rst_prio_busy", 32'(b_busy1), 32'd0);

        // port independence
        iss = 1'b1; ireg = 5'd12;
        step();
        rr1 = 5'd12; rr2 = 5'd12;
        wr = 1'b1; wreg = 5'd13; wdata = 32'h1313; iss = 1'b1; ireg = 5'd14;
        #1;
        check("indep_busy1", 32'(b_busy1), 32'd1);
        check("indep_busy2", 32'(b_busy2), 32'd1);
        check("indep_cnt_before", 32'(b_cnt), 32'd1);
        step();
        idle(); rr1 = 5'd13; rr2 = 5'd14;
        #1;
        check("indep_x13", b_rd1, 32'h1313);
        check("indep_cnt_after", 32'(b_cnt), 32'd2);
        check("indep_busy_x14", 32'(b_busy2), 32'd1);

        // unknown addresses with enables low
        wreg = 5'bxxxxx; ireg = 5'bxxxxx; wdata = 32'hFFFFFFFF;
        step();
        step();
        #1;
        check("x_addr_cnt", 32'(b_cnt), 32'd2);
        check("x_addr_x13", b_rd1, 32'h1313);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
